// File: rtl/vc_flit_serializer.sv
// Per-VC flit FIFOs with round-robin arbitration at flit boundaries; each flit is
// serialized LSB-first onto a narrow phit link with valid/ready and a last-phit marker.
module vc_flit_serializer #(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned PHIT_W     = 4,
  parameter int unsigned NUM_VC     = 4,
  parameter int unsigned VC_W       = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned FIFO_ADDRW = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic [VC_W-1:0]   in_vc,
  output logic              in_ready,
  output logic [PHIT_W-1:0] out_data,
  output logic              out_valid,
  output logic [VC_W-1:0]   out_vc,
  output logic              out_last,
  input  logic              out_ready,
  output logic [NUM_VC-1:0] vc_nonempty
);

  localparam int unsigned BEATS  = DATA_W / PHIT_W;
  localparam int unsigned BEAT_W = $clog2(BEATS + 1);
  localparam int unsigned CNT_W  = FIFO_ADDRW + 1;

  typedef enum logic {S_IDLE, S_SEND} state_e;

  state_e                state_q;
  logic [BEAT_W-1:0]     beat_q;
  logic [DATA_W-1:0]     sreg_q;
  logic [VC_W-1:0]       last_grant_q;

  logic [DATA_W-1:0]     mem_q   [NUM_VC][FIFO_DEPTH];
  logic [FIFO_ADDRW-1:0] head_q  [NUM_VC];
  logic [FIFO_ADDRW-1:0] tail_q  [NUM_VC];
  logic [CNT_W-1:0]      count_q [NUM_VC];
  logic [CNT_W-1:0]      count_d [NUM_VC];

  logic                  vc_ok;
  logic                  sel_full;
  logic                  adv;
  logic                  grant_found;
  logic                  load;
  logic [VC_W-1:0]       grant_vc;
  logic [DATA_W-1:0]     head_flit;
  logic [NUM_VC-1:0]     push_v;
  logic [NUM_VC-1:0]     pop_v;

  function automatic logic [FIFO_ADDRW-1:0] ptr_inc(input logic [FIFO_ADDRW-1:0] p);
    return (p == FIFO_ADDRW'(FIFO_DEPTH - 1)) ? '0 : p + FIFO_ADDRW'(1);
  endfunction

  // Upstream ready looks only at the current count of the addressed FIFO.
  always_comb begin : in_ready_logic
    vc_ok    = 32'(in_vc) < NUM_VC;
    sel_full = 1'b0;
    for (int unsigned i = 0; i < NUM_VC; i++) begin
      if (in_vc == VC_W'(i)) sel_full = (count_q[i] == CNT_W'(FIFO_DEPTH));
    end
    in_ready = vc_ok && !sel_full;
  end

  // Round-robin: first non-empty VC above the last grant, else lowest non-empty.
  always_comb begin : arbiter
    grant_found = 1'b0;
    grant_vc    = '0;
    for (int unsigned i = 0; i < NUM_VC; i++) begin
      if (!grant_found && vc_nonempty[i] && (VC_W'(i) > last_grant_q)) begin
        grant_found = 1'b1;
        grant_vc    = VC_W'(i);
      end
    end
    for (int unsigned i = 0; i < NUM_VC; i++) begin
      if (!grant_found && vc_nonempty[i]) begin
        grant_found = 1'b1;
        grant_vc    = VC_W'(i);
      end
    end
    head_flit = '0;
    for (int unsigned i = 0; i < NUM_VC; i++) begin
      if (grant_vc == VC_W'(i)) head_flit = mem_q[i][head_q[i]];
    end
  end

  assign adv  = !out_valid || out_ready;
  assign load = adv && grant_found && ((state_q == S_IDLE) || out_last);

  always_comb begin : fifo_next
    push_v = '0;
    pop_v  = '0;
    for (int unsigned i = 0; i < NUM_VC; i++) begin
      push_v[i]  = in_valid && in_ready && (in_vc == VC_W'(i));
      pop_v[i]   = load && (grant_vc == VC_W'(i));
      count_d[i] = count_q[i] + CNT_W'(push_v[i]) - CNT_W'(pop_v[i]);
    end
  end

  always_ff @(posedge clk) begin : fifo_ptrs
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_VC; i++) begin
        head_q[i]  <= '0;
        tail_q[i]  <= '0;
        count_q[i] <= '0;
      end
      vc_nonempty <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_VC; i++) begin
        count_q[i]     <= count_d[i];
        vc_nonempty[i] <= (count_d[i] != '0);
        if (push_v[i]) tail_q[i] <= ptr_inc(tail_q[i]);
        if (pop_v[i])  head_q[i] <= ptr_inc(head_q[i]);
      end
    end
  end

  // Payload storage is not reset; counts alone define validity.
  always_ff @(posedge clk) begin : fifo_mem
    for (int unsigned i = 0; i < NUM_VC; i++) begin
      if (push_v[i]) mem_q[i][tail_q[i]] <= in_data;
    end
  end

  // Serializer FSM; everything holds while a presented phit is stalled.
  always_ff @(posedge clk) begin : serializer
    if (!rst) begin
      state_q      <= S_IDLE;
      beat_q       <= '0;
      sreg_q       <= '0;
      last_grant_q <= VC_W'(NUM_VC - 1);
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_vc       <= '0;
      out_last     <= 1'b0;
    end else if (adv) begin
      if (load) begin
        state_q      <= S_SEND;
        sreg_q       <= head_flit >> PHIT_W;
        out_data     <= head_flit[PHIT_W-1:0];
        out_vc       <= grant_vc;
        out_valid    <= 1'b1;
        out_last     <= 1'b0;
        beat_q       <= BEAT_W'(1);
        last_grant_q <= grant_vc;
      end else if ((state_q == S_SEND) && !out_last) begin
        out_data <= sreg_q[PHIT_W-1:0];
        sreg_q   <= sreg_q >> PHIT_W;
        out_last <= (beat_q == BEAT_W'(BEATS - 1));
        beat_q   <= beat_q + BEAT_W'(1);
      end else begin
        state_q   <= S_IDLE;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vc_flit_serializer.sv
// Bench for vc_flit_serializer: directed scenarios plus random traffic checked
// against a queue-based transaction model of the per-VC FIFOs and arbiter.
module tb_vc_flit_serializer;

  localparam int DATA_W = 64;
  localparam int PHIT_W = 4;
  localparam int NUM_VC = 4;
  localparam int VC_W   = 2;
  localparam int DEPTH  = 4;
  localparam int BEATS  = DATA_W / PHIT_W;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic [VC_W-1:0]   in_vc = '0;
  logic              in_ready;
  logic [PHIT_W-1:0] out_data;
  logic              out_valid;
  logic [VC_W-1:0]   out_vc;
  logic              out_last;
  logic              out_ready = 1'b0;
  logic [NUM_VC-1:0] vc_nonempty;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  vc_flit_serializer #(
    .DATA_W(DATA_W), .PHIT_W(PHIT_W), .NUM_VC(NUM_VC), .VC_W(VC_W),
    .FIFO_DEPTH(DEPTH), .FIFO_ADDRW(2)
  ) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_vc(in_vc), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_vc(out_vc), .out_last(out_last),
    .out_ready(out_ready), .vc_nonempty(vc_nonempty)
  );

  // Reference model: one queue of tagged flits, per-VC order by search.
  typedef struct packed {
    logic [VC_W-1:0]   vc;
    logic [DATA_W-1:0] d;
  } ent_t;

  ent_t              mq[$];
  int                m_lg = NUM_VC - 1;
  bit                m_valid = 1'b0;
  logic [DATA_W-1:0] m_cur = '0;
  int                m_vc = 0;
  int                m_idx = 0;

  function automatic int m_cnt(int v);
    int n = 0;
    foreach (mq[i]) if (int'(mq[i].vc) == v) n++;
    return n;
  endfunction

  function automatic logic [DATA_W-1:0] m_pop(int v);
    logic [DATA_W-1:0] r = '0;
    for (int i = 0; i < mq.size(); i++) begin
      if (int'(mq[i].vc) == v) begin
        r = mq[i].d;
        mq.delete(i);
        break;
      end
    end
    return r;
  endfunction

  task automatic model_edge();
    bit acc;
    bit adv;
    int g;
    acc = in_valid && (int'(in_vc) < NUM_VC) && (m_cnt(int'(in_vc)) < DEPTH);
    if (!rst) begin
      mq.delete();
      m_lg = NUM_VC - 1;
      m_valid = 1'b0;
      m_idx = 0;
      m_vc = 0;
      return;
    end
    adv = !m_valid || out_ready;
    if (adv) begin
      if (m_valid && m_idx < BEATS - 1) begin
        m_idx++;
      end else begin
        g = -1;
        for (int k = 1; k <= NUM_VC; k++) begin
          if (g < 0 && m_cnt((m_lg + k) % NUM_VC) > 0) g = (m_lg + k) % NUM_VC;
        end
        if (g >= 0) begin
          m_cur = m_pop(g);
          m_vc = g;
          m_lg = g;
          m_idx = 0;
          m_valid = 1'b1;
        end else begin
          m_valid = 1'b0;
        end
      end
    end
    if (acc) mq.push_back({in_vc, in_data});
  endtask

  function automatic logic [12:0] exp_vec();
    logic [NUM_VC-1:0] ne;
    logic rdy;
    for (int v = 0; v < NUM_VC; v++) ne[v] = (m_cnt(v) > 0);
    rdy = (int'(in_vc) < NUM_VC) && (m_cnt(int'(in_vc)) < DEPTH);
    if (!m_valid) return {rdy, ne, 1'b0, 2'b0, 4'b0, 1'b0};
    return {rdy, ne, 1'b1, 2'(m_vc), m_cur[m_idx*PHIT_W +: PHIT_W], (m_idx == BEATS - 1)};
  endfunction

  function automatic logic [12:0] obs_vec();
    return {in_ready, vc_nonempty, out_valid,
            out_valid ? out_vc : 2'b0, out_valid ? out_data : 4'b0, out_valid & out_last};
  endfunction

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b1; in_vc = 2'd2; in_data = rnd64(); out_ready = 1'b1;
    step();
    step();
    tests++;
    if ({out_valid, out_data, out_vc, out_last, vc_nonempty} !== 12'h000) begin
      fails++;
      $display("FAIL reset_outputs got %h required 000",
               {out_valid, out_data, out_vc, out_last, vc_nonempty});
    end
    in_valid = 1'b0; rst = 1'b1;
    step();
    tests++;
    if (obs_vec() !== exp_vec()) begin
      fails++; $display("FAIL reset_model got %h required %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_single_flit();
    logic [DATA_W-1:0] d = 64'h0123_4567_89AB_CDEF;
    logic [7:0] got, want;
    out_ready = 1'b1; in_valid = 1'b1; in_vc = 2'd2; in_data = d;
    step();
    in_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL single_latency out_valid=%b required 0", out_valid);
    end
    for (int k = 0; k < BEATS; k++) begin
      step();
      got  = {out_valid, out_vc, out_data, out_last};
      want = {1'b1, 2'd2, d[k*PHIT_W +: PHIT_W], (k == BEATS - 1)};
      tests++;
      if (got !== want) begin
        fails++; $display("FAIL single_phit%0d got %h required %h", k, got, want);
      end
    end
    step();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL single_idle out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [DATA_W-1:0] d[NUM_VC];
    logic [7:0] got, want;
    rst = 1'b0; in_valid = 1'b0;
    step();
    rst = 1'b1; out_ready = 1'b0;
    for (int v = 0; v < NUM_VC; v++) begin
      d[v] = rnd64(); in_valid = 1'b1; in_vc = 2'(v); in_data = d[v];
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < NUM_VC * BEATS; k++) begin
      got  = {out_valid, out_vc, out_data, out_last};
      want = {1'b1, 2'(k / BEATS), d[k / BEATS][(k % BEATS)*PHIT_W +: PHIT_W], ((k % BEATS) == BEATS - 1)};
      tests++;
      if (got !== want) begin
        fails++; $display("FAIL rr_phit%0d got %h required %h", k, got, want);
      end
      step();
    end
    tests++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL rr_end out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] d = rnd64();
    int n = 0;
    int stall = 0;
    in_valid = 1'b1; in_vc = 2'd1; in_data = d; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int cyc = 0; cyc < 100 && n < BEATS; cyc++) begin
      if (n == 7 && stall < 5) begin
        out_ready = 1'b0; stall++;
      end else begin
        out_ready = 1'b1;
      end
      if (!out_ready) begin
        tests++;
        if ({out_valid, out_data, out_vc, out_last} !== {1'b1, d[7*PHIT_W +: PHIT_W], 2'd1, 1'b0}) begin
          fails++; $display("FAIL bp_hold got %h required %h", {out_valid, out_data, out_vc, out_last},
                            {1'b1, d[7*PHIT_W +: PHIT_W], 2'd1, 1'b0});
        end
      end else if (out_valid) begin
        tests++;
        if ({out_data, out_vc, out_last} !== {d[n*PHIT_W +: PHIT_W], 2'd1, (n == BEATS - 1)}) begin
          fails++; $display("FAIL bp_phit%0d got %h required %h", n, {out_data, out_vc, out_last},
                            {d[n*PHIT_W +: PHIT_W], 2'd1, (n == BEATS - 1)});
        end
        n++;
      end
      step();
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL bp_model got %h required %h", obs_vec(), exp_vec());
      end
    end
    tests++;
    if (n != BEATS || stall != 5) begin
      fails++; $display("FAIL bp_count phits=%0d stalls=%0d required %0d/5", n, stall, BEATS);
    end
  endtask

  task automatic test_full_fifo();
    logic [DATA_W-1:0] expf[5];
    logic [DATA_W-1:0] acc = '0;
    int nb = 0;
    int nf = 0;
    rst = 1'b0; in_valid = 1'b0;
    step();
    rst = 1'b1; out_ready = 1'b0;
    expf[0] = rnd64(); in_valid = 1'b1; in_vc = 2'd0; in_data = expf[0];
    step();
    in_valid = 1'b0;
    step();
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_vc = 2'd1; in_data = rnd64();
      if (k < 4) expf[k+1] = in_data;
      #1;
      tests++;
      if (in_ready !== (k < 4)) begin
        fails++; $display("FAIL full_ready push%0d in_ready=%b required %b", k, in_ready, (k < 4));
      end
      step();
    end
    in_valid = 1'b0;
    tests++;
    if (vc_nonempty !== 4'b0010) begin
      fails++; $display("FAIL full_nonempty got %b required 0010", vc_nonempty);
    end
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 200 && nf < 5; cyc++) begin
      if (out_valid && out_ready) begin
        acc[nb*PHIT_W +: PHIT_W] = out_data;
        nb++;
        if (out_last) begin
          tests++;
          if (acc !== expf[nf] || nb != BEATS) begin
            fails++; $display("FAIL full_drain%0d got %h (%0d phits) required %h", nf, acc, nb, expf[nf]);
          end
          nf++; nb = 0;
        end
      end
      step();
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL full_model got %h required %h", obs_vec(), exp_vec());
      end
    end
    tests++;
    if (nf != 5) begin
      fails++; $display("FAIL full_drain_count got %0d required 5", nf);
    end
  endtask

  task automatic test_wrap();
    logic [DATA_W-1:0] sent[10];
    logic [DATA_W-1:0] acc = '0;
    int ns = 0;
    int nr = 0;
    int nb = 0;
    bit accepted;
    foreach (sent[i]) sent[i] = rnd64();
    for (int cyc = 0; cyc < 1000 && nr < 10; cyc++) begin
      in_valid = (ns < 10) && ($urandom_range(0, 3) != 0);
      in_vc = 2'd3; in_data = sent[ns < 10 ? ns : 9];
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      accepted = in_valid && in_ready;
      if (out_valid && out_ready) begin
        acc[nb*PHIT_W +: PHIT_W] = out_data;
        nb++;
        if (out_last) begin
          tests++;
          if (acc !== sent[nr] || nb != BEATS || out_vc !== 2'd3) begin
            fails++; $display("FAIL wrap_flit%0d got %h vc=%0d required %h vc=3", nr, acc, out_vc, sent[nr]);
          end
          nr++; nb = 0;
        end
      end
      step();
      if (accepted) ns++;
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL wrap_model got %h required %h", obs_vec(), exp_vec());
      end
    end
    in_valid = 1'b0;
    tests++;
    if (nr != 10 || ns != 10) begin
      fails++; $display("FAIL wrap_count recv=%0d sent=%0d required 10/10", nr, ns);
    end
  endtask

  task automatic test_reset_mid();
    logic [DATA_W-1:0] d = rnd64();
    logic [DATA_W-1:0] d2 = rnd64();
    int n = 0;
    out_ready = 1'b1; in_valid = 1'b1; in_vc = 2'd2; in_data = d;
    step();
    in_vc = 2'd0; in_data = rnd64();
    step();
    in_valid = 1'b0;
    for (int cyc = 0; cyc < 50 && n < 9; cyc++) begin
      if (out_valid && out_ready) n++;
      step();
    end
    tests++;
    if ({out_valid, out_data, vc_nonempty[0]} !== {1'b1, d[9*PHIT_W +: PHIT_W], 1'b1}) begin
      fails++; $display("FAIL rmid_pre got %h required %h", {out_valid, out_data, vc_nonempty[0]},
                        {1'b1, d[9*PHIT_W +: PHIT_W], 1'b1});
    end
    rst = 1'b0;
    step();
    rst = 1'b1;
    tests++;
    if ({out_valid, vc_nonempty} !== 5'b0) begin
      fails++; $display("FAIL rmid_reset got %b required 00000", {out_valid, vc_nonempty});
    end
    in_valid = 1'b1; in_vc = 2'd1; in_data = d2;
    step();
    in_valid = 1'b0;
    step();
    tests++;
    if ({out_valid, out_vc, out_data, out_last} !== {1'b1, 2'd1, d2[PHIT_W-1:0], 1'b0}) begin
      fails++; $display("FAIL rmid_restart got %h required %h", {out_valid, out_vc, out_data, out_last},
                        {1'b1, 2'd1, d2[PHIT_W-1:0], 1'b0});
    end
    for (int cyc = 0; cyc < 40 && out_valid; cyc++) begin
      step();
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL rmid_model got %h required %h", obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 900; cyc++) begin
      in_valid = (cyc < 800) && ($urandom_range(0, 1) != 0);
      in_vc = 2'($urandom_range(0, NUM_VC - 1));
      in_data = rnd64();
      out_ready = (cyc >= 800) || ($urandom_range(0, 4) != 0);
      step();
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL random_model cyc=%0d got %h required %h", cyc, obs_vec(), exp_vec());
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_flit();
    test_round_robin();
    test_backpressure();
    test_full_fifo();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vc_flit_serializer.md
Name: vc_flit_serializer

Overview:
- Parametrised successor to the single-queue 64-to-4 serializer in the NoC link path.
- Takes full-width flits tagged with a virtual channel and queues them in per-VC FIFOs.
- Arbitrates round-robin between VCs at flit boundaries and emits each flit as LSB-first phits on a narrow link.
- Adds downstream backpressure (valid/ready), upstream ready and a last-phit marker, none of which the previous generation had.

Parameters:
DATA_W, 64, flit width in bits; must be an integer multiple of PHIT_W
PHIT_W, 4, link (phit) width in bits; BEATS = DATA_W/PHIT_W, BEATS >= 2
NUM_VC, 4, number of virtual channels, >= 2
VC_W, 2, VC index width, = clog2(NUM_VC)
FIFO_DEPTH, 4, entries per VC FIFO, >= 1
FIFO_ADDRW, 2, FIFO pointer width, >= clog2(FIFO_DEPTH)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-low reset
in_data  input  DATA_W  flit payload
in_valid  input  1  flit offered
in_vc  input  VC_W  target VC of offered flit; values >= NUM_VC are never accepted
in_ready  output  1  combinational: in_vc < NUM_VC and FIFO[in_vc] not full
out_data  output  PHIT_W  current phit
out_valid  output  1  phit valid
out_vc  output  VC_W  VC of the flit being sent
out_last  output  1  high on the final phit (index BEATS-1) of a flit
out_ready  input  1  downstream accepts phit this cycle
vc_nonempty  output  NUM_VC  bit i high when FIFO i holds at least one entry (registered state, no bypass)

Behaviour:
- Reset (rst=0 at an edge): all FIFO counts, pointers, beat counter, shift register, arbiter pointer and state cleared. Outputs after that edge: out_valid=0, out_data=0, out_vc=0, out_last=0, vc_nonempty=0. A flit in flight is abandoned; no partial resumption. FIFO contents need not be cleared.
- Enqueue: when in_valid && in_ready at an edge, write the flit to FIFO[in_vc] at its tail. Tail wraps from FIFO_DEPTH-1 to 0.
- A full FIFO never accepts, even if the same edge pops it; in_ready depends on the current count only.
- Advance condition: adv = !out_valid || out_ready. While out_valid && !out_ready, out_data, out_vc, out_last and all internal state are held stable.
- FSM states:
  - IDLE: on an edge with adv=1 and any FIFO non-empty, grant one VC, pop its head, and load the shift register. Register out_data = flit[PHIT_W-1:0], out_vc = granted VC, out_valid=1, out_last=0, beat=1, then go to SEND. Otherwise out_valid <= 0.
  - SEND: on an edge with adv=1 and beat < BEATS, present phit[beat] (bits beat*PHIT_W +: PHIT_W), set out_last = (beat == BEATS-1), and increment beat.
  - SEND, after the last phit: when the last phit is accepted (out_last && out_ready) and any FIFO is non-empty, arbitrate and load phit 0 of the next flit at that same edge (no bubble), staying in SEND. If all FIFOs are empty, out_valid <= 0 and go to IDLE.
- Arbitration: round-robin. Search starts at (last_grant+1) mod NUM_VC, and last_grant updates on each grant. last_grant resets to NUM_VC-1, so VC0 has first priority.
- Selection uses FIFO state before same-edge enqueues, so a flit written at edge E is eligible at edge E+1 at the earliest.
- Latency: flit accepted at edge E into an idle block gives phit 0 valid after E+1 and the last phit after E+BEATS, assuming out_ready stays high.
- Simultaneous enqueue and pop on the same VC: count unchanged; head and tail both advance.
- Counts: FIFO_ADDRW+1 bits; full = (count == FIFO_DEPTH), empty = (count == 0).
- Phit order: LSB first. Every flit emits exactly BEATS phits with exactly one out_last pulse.

Test Plan:
- Reset then single flit: in_vc=2, in_data=64'h0123_4567_89AB_CDEF, out_ready=1 → phits F,E,D,C,...,1,0 on 16 consecutive cycles starting one cycle after accept. out_vc=2 throughout, out_last only on the 16th phit, then out_valid=0.
- Round-robin: one flit each loaded into VC0..VC3 before the first grant → flits emerge in VC order 0,1,2,3 with no idle cycle between flits (64 contiguous valid phits).
- Backpressure: hold out_ready=0 for 5 cycles at phit 7 → out_data, out_vc and out_last held stable throughout. The full flit still totals 16 accepted phits, in order.
- Full FIFO: push 5 flits to VC1 with out_ready=0 → in_ready drops after the 4th accept. The 5th is not accepted and vc_nonempty=4'b0010; all 4 accepted flits later drain in FIFO order.
- Wrap-around: stream 10 flits through VC3 with concurrent push/pop → output matches input order across pointer wrap, with no loss or duplication.
- Reset mid-flit: assert rst=0 at phit 9 → out_valid=0 and vc_nonempty=0 after that edge. The next flit sent afterwards starts at phit 0.
